// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: shared types, frame constants and timeout helper for the PS/2 receiver
package ps2_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  function automatic int timeout_reload(input int clk_hz, input int timeout_us);
    return clk_hz / 1_000_000 * timeout_us;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; head holds its last value once drained
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             pop, wr;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign pop     = rd_i && !empty_o;
  assign wr      = wr_i && (!full_o || pop);
  assign rdata_o = empty_o ? last_q : mem_q[rp_q];
  assign count_o = cnt_q;
  // storage array needs no reset; reads are masked by last_q while empty
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wdata_i;
  end
  // pointers, occupancy and the held head value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + AW'(1);
      if (pop) begin
        rp_q   <= rp_q + AW'(1);
        last_q <= mem_q[rp_q];
      end
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
    end
  end
endmodule

// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend: PS/2 pin synchroniser, clock deglitcher, frame checker and byte FIFO
module ps2_rx_frontend
  import ps2_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILT_LEN   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int TO_RELOAD = timeout_reload(CLK_HZ, TIMEOUT_US);
  localparam int TW = $clog2(TO_RELOAD + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int BW = $clog2(DATA_BITS);
  logic [1:0]           clk_sync_q, dat_sync_q;
  logic                 clk_f_q, clk_f_prev_q, fall_stb_q;
  logic [FW-1:0]        filt_cnt_q;
  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 par_q;
  logic [TW-1:0]        to_q;
  logic                 parity_err_q, frame_err_q, overflow_q;
  logic                 s_clk, s_dat, push, full, empty;
  assign s_clk = clk_sync_q[1];
  assign s_dat = dat_sync_q[1];
  assign push  = fall_stb_q && state_q == STOP && (^{shift_q, par_q}) && s_dat == STOP_BIT;
  assign valid_o      = !empty;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  // two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end
  // clk_f follows the pin only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_f_q    <= 1'b1;
      filt_cnt_q <= '0;
    end else if (s_clk == clk_f_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
      clk_f_q    <= s_clk;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end
  // one-cycle strobe the cycle after the filtered clock falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_f_prev_q <= 1'b1;
      fall_stb_q   <= 1'b0;
    end else begin
      clk_f_prev_q <= clk_f_q;
      fall_stb_q   <= clk_f_prev_q && !clk_f_q;
    end
  end
  // frame state machine with inter-edge timeout and registered error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      to_q         <= TW'(TO_RELOAD);
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      to_q <= (state_q == IDLE || fall_stb_q) ? TW'(TO_RELOAD) : to_q - TW'(1);
      if (fall_stb_q) begin
        case (state_q)
          IDLE: if (s_dat == START_BIT) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
          DATA: begin
            shift_q   <= {s_dat, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= s_dat;
            state_q <= STOP;
          end
          STOP: begin
            parity_err_q <= ~^{shift_q, par_q};
            frame_err_q  <= s_dat != STOP_BIT;
            state_q      <= IDLE;
          end
        endcase
      end else if (state_q != IDLE && to_q == '0) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
      end
    end
  end
  // a good byte is lost only when full and no pop frees a slot this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else overflow_q <= push && full && !(ready_i && !empty);
  end
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_i    (push),
    .wdata_i (shift_q),
    .rd_i    (ready_i),
    .rdata_o (data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count_o)
  );
endmodule
